// File: rtl/jk_reg_pkg.sv
// Shared types and constants for the JK-cell register.
// Mode encoding and per-bit JK control codes.
package jk_reg_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_UP   = 2'b10,
    MODE_DOWN = 2'b11
  } mode_t;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop bit with clock enable and registered complement output.
// Asynchronous active-low reset clears q and sets qbar.
module jk_cell
  import jk_reg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  // qbar is its own flop so it stays an exact registered complement of q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= 1'b0;
      qbar <= 1'b1;
    end else if (ce) begin
      case ({j, k})
        JK_CLR: begin
          q    <= 1'b0;
          qbar <= 1'b1;
        end
        JK_SET: begin
          q    <= 1'b1;
          qbar <= 1'b0;
        end
        JK_TOG: begin
          q    <= ~q;
          qbar <= ~qbar;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/jk_register.sv
// WIDTH-bit register of JK cells with per-bit JK control, parallel load and up/down counting.
// Define JKREG_SAT_EN to make the counting modes saturate instead of wrap.
module jk_register
  import jk_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  mode_t            op;
  logic [WIDTH-1:0] up_chain;
  logic [WIDTH-1:0] dn_chain;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic             at_bound;

  assign op = mode_t'(mode);

  // Synchronous toggle chains: a bit flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    up_chain    = '0;
    dn_chain    = '0;
    up_chain[0] = 1'b1;
    dn_chain[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_chain[i] = up_chain[i-1] & q[i-1];
      dn_chain[i] = dn_chain[i-1] & ~q[i-1];
    end
  end

  always_comb begin
    cell_j   = '0;
    cell_k   = '0;
    at_bound = 1'b0;
    case (op)
      MODE_JK: begin
        cell_j = j;
        cell_k = k;
      end
      MODE_LOAD: begin
        cell_j = d;
        cell_k = ~d;
      end
      MODE_UP: begin
        at_bound = &q;
        cell_j   = up_chain;
        cell_k   = up_chain;
      end
      MODE_DOWN: begin
        at_bound = ~|q;
        cell_j   = dn_chain;
        cell_k   = dn_chain;
      end
    endcase
`ifdef JKREG_SAT_EN
    if (at_bound) begin
      cell_j = '0;
      cell_k = '0;
    end
`endif
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .ce   (en),
      .j    (cell_j[i]),
      .k    (cell_k[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tc <= 1'b0;
    else        tc <= en & at_bound;
  end

endmodule

// File: tb/tb_jk_register.sv
// Self-checking bench for jk_register (WIDTH=4): directed plan steps then random traffic
// against an arithmetic reference model; honours JKREG_SAT_EN.
module tb_jk_register;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] j, k, d;
  logic [W-1:0] q, qbar;
  logic         tc;

  int           tests;
  int           fails;
  int           mq;
  logic         mtc;

  jk_register #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .mode (mode),
    .j    (j),
    .k    (k),
    .d    (d),
    .q    (q),
    .qbar (qbar),
    .tc   (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag);
    logic [W-1:0] eq;
    eq = mq[W-1:0];
    tests++;
    assert (q === eq) else begin
      fails++;
      $display("[TB] FAIL %s.q observed=%b expected=%b", tag, q, eq);
      $error("[TB] %s q mismatch", tag);
    end
    tests++;
    assert (qbar === ~eq) else begin
      fails++;
      $display("[TB] FAIL %s.qbar observed=%b expected=%b", tag, qbar, ~eq);
      $error("[TB] %s qbar mismatch", tag);
    end
    tests++;
    assert (tc === mtc) else begin
      fails++;
      $display("[TB] FAIL %s.tc observed=%b expected=%b", tag, tc, mtc);
      $error("[TB] %s tc mismatch", tag);
    end
  endtask

  // Drive one cycle of inputs, advance the model by the rules, then check after the edge.
  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [W-1:0] jj,
                               input logic [W-1:0] kk, input logic [W-1:0] dd, input string tag);
    int   nq;
    logic ntc;
    en = e; mode = m; j = jj; k = kk; d = dd;
    nq  = mq;
    ntc = 1'b0;
    if (e) begin
      case (m)
        2'b00: for (int b = 0; b < W; b++) begin
          if (jj[b] && kk[b])  nq = nq ^ (1 << b);
          else if (jj[b])      nq = nq | (1 << b);
          else if (kk[b])      nq = nq & ~(1 << b);
        end
        2'b01: nq = int'(dd);
        2'b10: begin
          ntc = (mq == (1 << W) - 1);
`ifdef JKREG_SAT_EN
          nq = ntc ? mq : mq + 1;
`else
          nq = (mq + 1) % (1 << W);
`endif
        end
        default: begin
          ntc = (mq == 0);
`ifdef JKREG_SAT_EN
          nq = ntc ? mq : mq - 1;
`else
          nq = (mq + (1 << W) - 1) % (1 << W);
`endif
        end
      endcase
    end
    @(posedge clk);
    #1;
    mq  = nq;
    mtc = ntc;
    checkOutput(tag);
  endtask

  // Assert reset between edges, check it acts at once, hold through an edge, release.
  task automatic pulseReset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    mq  = 0;
    mtc = 1'b0;
    checkOutput(tag);
    @(posedge clk);
    #1;
    checkOutput(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    mq    = 0;
    mtc   = 1'b0;
    rst_n = 1'b1;
    en    = 1'b0;
    mode  = 2'b00;
    j     = '0;
    k     = '0;
    d     = '0;
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_init");
    @(posedge clk);
    #1 checkOutput("reset_hold");
    rst_n = 1'b1;

    applyStimulus(1'b1, 2'b01, 4'b0000, 4'b0000, 4'b1010, "load_1010");
    pulseReset("reset_mid");

    applyStimulus(1'b1, 2'b00, 4'b1100, 4'b1010, 4'b0000, "jk_mixed");
    applyStimulus(1'b1, 2'b00, 4'b1111, 4'b1111, 4'b0000, "jk_toggle");
    applyStimulus(1'b1, 2'b00, 4'b0000, 4'b0000, 4'b1111, "jk_hold");

    applyStimulus(1'b1, 2'b01, 4'b1111, 4'b1111, 4'b0110, "load_0110");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 2'b01, 4'b1111, 4'b0000, 4'b1111, "en_off_hold");

    applyStimulus(1'b1, 2'b01, 4'b0000, 4'b0000, 4'b1110, "load_1110");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, "up_wrap");
    applyStimulus(1'b0, 2'b10, 4'b0000, 4'b0000, 4'b0000, "up_pause");

    applyStimulus(1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0001, "load_0001");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, "down_wrap");

    applyStimulus(1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0101, "load_0101");
    applyStimulus(1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000, "switch_up");
    applyStimulus(1'b1, 2'b11, 4'b0000, 4'b0000, 4'b0000, "switch_down");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        pulseReset("rand_reset");
      end else begin
        applyStimulus(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                      4'($urandom), 4'($urandom), 4'($urandom), "random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
